// File: rtl/sync_fifo_pkt.sv
// Packet-aware synchronous FIFO with store-and-forward or cut-through read side.
// Optional packet drop on wdrop is built only when SYNC_FIFO_PKT_DROP_EN is defined.
module sync_fifo_pkt #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int STORE_FWD     = 1,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int CNT_WIDTH     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wlast,
  input  logic                  wdrop,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [CNT_WIDTH-1:0]  data_count,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  oversize,
  output logic                  dropped
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef enum logic {ST_ACCEPT, ST_DISCARD} wr_state_e;

  logic [DATA_WIDTH:0]  r_mem [DEPTH];
  ptr_t                 r_wptr, r_cptr, r_rptr;
  wr_state_e            r_state;
  logic [CNT_WIDTH-1:0] r_pkt_count;
  logic                 r_oversize, r_dropped;

  logic [CNT_WIDTH-1:0] w_data_count;
  logic [DATA_WIDTH:0]  w_rword;
  logic w_full, w_discard, w_wready, w_rvalid;
  logic w_wr_beat, w_rd_beat, w_rd_last;
  logic w_drop_req, w_drop, w_store, w_commit, w_overflow;

  // Index runs 0..DEPTH-1 then wraps and flips the extra bit, so non-power-of-two depths work.
  function automatic ptr_t ptr_inc(input ptr_t p);
    ptr_t n;
    if (p[IW-1:0] == IW'(DEPTH - 1)) n = {~p[IW], {IW{1'b0}}};
    else                             n = {p[IW], p[IW-1:0] + IW'(1)};
    return n;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] ptr_diff(input ptr_t w, input ptr_t r);
    logic [CNT_WIDTH-1:0] d;
    if (w[IW] == r[IW]) d = CNT_WIDTH'(w[IW-1:0]) - CNT_WIDTH'(r[IW-1:0]);
    else                d = CNT_WIDTH'(DEPTH) - CNT_WIDTH'(r[IW-1:0]) + CNT_WIDTH'(w[IW-1:0]);
    return d;
  endfunction

`ifdef SYNC_FIFO_PKT_DROP_EN
  assign w_drop_req = (STORE_FWD != 0) && wlast && wdrop;
`else
  logic w_unused_wdrop;
  assign w_unused_wdrop = wdrop;
  assign w_drop_req     = 1'b0;
`endif

  assign w_data_count = ptr_diff(r_wptr, r_rptr);
  assign w_full       = (w_data_count == CNT_WIDTH'(DEPTH));
  assign w_discard    = (r_state == ST_DISCARD);
  assign w_wready     = w_discard | ~w_full;
  assign w_rvalid     = (STORE_FWD != 0) ? (r_rptr != r_cptr) : (r_rptr != r_wptr);
  assign w_rword      = r_mem[r_rptr[IW-1:0]];

  assign w_wr_beat  = wvalid & w_wready;
  assign w_rd_beat  = w_rvalid & rready;
  assign w_rd_last  = w_rd_beat & w_rword[DATA_WIDTH];
  assign w_drop     = w_wr_beat & ~w_discard & w_drop_req;
  assign w_store    = w_wr_beat & ~w_discard & ~w_drop;
  assign w_commit   = w_store & wlast;
  // Full with nothing committed ahead of the read head: this packet can never fit.
  assign w_overflow = (STORE_FWD != 0) && !w_discard && w_full && (r_cptr == r_rptr);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr      <= '0;
      r_cptr      <= '0;
      r_rptr      <= '0;
      r_state     <= ST_ACCEPT;
      r_pkt_count <= '0;
      r_oversize  <= 1'b0;
      r_dropped   <= 1'b0;
    end else if (flush) begin
      r_wptr      <= '0;
      r_cptr      <= '0;
      r_rptr      <= '0;
      r_state     <= ST_ACCEPT;
      r_pkt_count <= '0;
      r_oversize  <= 1'b0;
      r_dropped   <= 1'b0;
    end else begin
      r_oversize <= 1'b0;
      r_dropped  <= 1'b0;
      if (w_rd_beat) r_rptr <= ptr_inc(r_rptr);

      if (w_discard) begin
        if (w_wr_beat && wlast) r_state <= ST_ACCEPT;
      end else if (w_overflow) begin
        r_wptr     <= r_cptr;
        r_oversize <= 1'b1;
        r_state    <= ST_DISCARD;
      end else if (w_drop) begin
        r_wptr    <= r_cptr;
        r_dropped <= 1'b1;
      end else if (w_store) begin
        r_wptr <= ptr_inc(r_wptr);
        if (wlast || STORE_FWD == 0) r_cptr <= ptr_inc(r_wptr);
      end

      if (w_commit && !w_rd_last)      r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
      else if (!w_commit && w_rd_last) r_pkt_count <= r_pkt_count - CNT_WIDTH'(1);
    end
  end

  // NOTE: storage has no reset; pointers alone define which words are valid.
  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_wptr[IW-1:0]] <= {wlast, wdata};
  end

  assign wready       = w_wready;
  assign rvalid       = w_rvalid;
  assign rdata        = w_rvalid ? w_rword[DATA_WIDTH-1:0] : '0;
  assign rlast        = w_rvalid & w_rword[DATA_WIDTH];
  assign data_count   = w_data_count;
  assign pkt_count    = r_pkt_count;
  assign almost_full  = (w_data_count >= CNT_WIDTH'(AFULL_THRESH));
  assign almost_empty = (w_data_count <= CNT_WIDTH'(AEMPTY_THRESH));
  assign oversize     = r_oversize;
  assign dropped      = r_dropped;

endmodule

// File: tb/tb_sync_fifo_pkt.sv
// Self-checking bench for sync_fifo_pkt: store-forward instance (DEPTH=16) and cut-through instance (DEPTH=5).
// Read data is checked against scoreboard queues filled when stimulus is driven.
module tb_sync_fifo_pkt;

  logic clk = 1'b0;
  logic reset;

  logic       sf_flush, sf_wlast, sf_wdrop, sf_wvalid, sf_rready;
  logic [7:0] sf_wdata, sf_rdata;
  logic       sf_wready, sf_rlast, sf_rvalid;
  logic [4:0] sf_data_count, sf_pkt_count;
  logic       sf_almost_full, sf_almost_empty, sf_oversize, sf_dropped;

  logic       ct_flush, ct_wlast, ct_wdrop, ct_wvalid, ct_rready;
  logic [7:0] ct_wdata, ct_rdata;
  logic       ct_wready, ct_rlast, ct_rvalid;
  logic [2:0] ct_data_count, ct_pkt_count;
  logic       ct_almost_full, ct_almost_empty, ct_oversize, ct_dropped;

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] sf_q[$];
  logic [8:0] ct_q[$];

`ifdef SYNC_FIFO_PKT_DROP_EN
  localparam int EXP_DROP = 1;
  localparam logic [4:0] EXP_PKTS = 5'd2;
`else
  localparam int EXP_DROP = 0;
  localparam logic [4:0] EXP_PKTS = 5'd3;
`endif

  localparam logic [24:0] SF_RST = {1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [20:0] CT_RST = {1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0};

  sync_fifo_pkt #(.DATA_WIDTH(8), .DEPTH(16), .STORE_FWD(1)) u_sf (
    .clk(clk), .reset(reset), .flush(sf_flush),
    .wdata(sf_wdata), .wlast(sf_wlast), .wdrop(sf_wdrop), .wvalid(sf_wvalid), .wready(sf_wready),
    .rdata(sf_rdata), .rlast(sf_rlast), .rvalid(sf_rvalid), .rready(sf_rready),
    .data_count(sf_data_count), .pkt_count(sf_pkt_count),
    .almost_full(sf_almost_full), .almost_empty(sf_almost_empty),
    .oversize(sf_oversize), .dropped(sf_dropped)
  );

  sync_fifo_pkt #(.DATA_WIDTH(8), .DEPTH(5), .STORE_FWD(0)) u_ct (
    .clk(clk), .reset(reset), .flush(ct_flush),
    .wdata(ct_wdata), .wlast(ct_wlast), .wdrop(ct_wdrop), .wvalid(ct_wvalid), .wready(ct_wready),
    .rdata(ct_rdata), .rlast(ct_rlast), .rvalid(ct_rvalid), .rready(ct_rready),
    .data_count(ct_data_count), .pkt_count(ct_pkt_count),
    .almost_full(ct_almost_full), .almost_empty(ct_almost_empty),
    .oversize(ct_oversize), .dropped(ct_dropped)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [24:0] sf_status();
    return {sf_wready, sf_rvalid, sf_rlast, sf_rdata, sf_data_count, sf_pkt_count,
            sf_almost_full, sf_almost_empty, sf_oversize, sf_dropped};
  endfunction

  function automatic logic [20:0] ct_status();
    return {ct_wready, ct_rvalid, ct_rlast, ct_rdata, ct_data_count, ct_pkt_count,
            ct_almost_full, ct_almost_empty, ct_oversize, ct_dropped};
  endfunction

  // Advance one clock; read beats are scored at the falling edge, outputs settle #1 after the rising edge.
  task automatic tick();
    logic [8:0] exp_w;
    @(negedge clk);
    if (!reset && !sf_flush && sf_rvalid && sf_rready) begin
      n_tests++;
      if (sf_q.size() == 0) begin
        n_fail++;
        $display("FAIL sf_read got %h expected no word", {sf_rlast, sf_rdata});
      end else begin
        exp_w = sf_q.pop_front();
        if ({sf_rlast, sf_rdata} !== exp_w) begin
          n_fail++;
          $display("FAIL sf_read got {last,data}=%h expected %h", {sf_rlast, sf_rdata}, exp_w);
        end
      end
    end
    if (!reset && !ct_flush && ct_rvalid && ct_rready) begin
      n_tests++;
      if (ct_q.size() == 0) begin
        n_fail++;
        $display("FAIL ct_read got %h expected no word", {ct_rlast, ct_rdata});
      end else begin
        exp_w = ct_q.pop_front();
        if ({ct_rlast, ct_rdata} !== exp_w) begin
          n_fail++;
          $display("FAIL ct_read got {last,data}=%h expected %h", {ct_rlast, ct_rdata}, exp_w);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    sf_flush = 0; sf_wvalid = 0; sf_wlast = 0; sf_wdrop = 0; sf_rready = 0; sf_wdata = '0;
    ct_flush = 0; ct_wvalid = 0; ct_wlast = 0; ct_wdrop = 0; ct_rready = 0; ct_wdata = '0;
  endtask

  task automatic sf_write(input logic [7:0] d, input logic l, input logic drp);
    int budget = 0;
    sf_wvalid = 1; sf_wdata = d; sf_wlast = l; sf_wdrop = drp;
    while (!sf_wready && budget < 64) begin
      tick();
      budget++;
    end
    if (budget >= 64) begin
      n_tests++; n_fail++;
      $display("FAIL sf_write_timeout got wready=0 expected 1 within 64 cycles");
    end
    tick();
    sf_wvalid = 0; sf_wlast = 0; sf_wdrop = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    idle_all();
    #3;
    n_tests++;
    if (sf_status() !== SF_RST) begin
      n_fail++; $display("FAIL reset_sf got %h expected %h", sf_status(), SF_RST);
    end
    n_tests++;
    if (ct_status() !== CT_RST) begin
      n_fail++; $display("FAIL reset_ct got %h expected %h", ct_status(), CT_RST);
    end
    tick(); tick();
    reset = 0;
    tick();
    n_tests++;
    if (sf_status() !== SF_RST) begin
      n_fail++; $display("FAIL reset_release_sf got %h expected %h", sf_status(), SF_RST);
    end
  endtask

  task automatic test_sf_latency();
    sf_rready = 1;
    for (int i = 0; i < 4; i++) begin
      sf_q.push_back({(i == 3), 8'(8'h11 + i)});
      n_tests++;
      if (sf_rvalid !== 1'b0) begin
        n_fail++; $display("FAIL sf_latency_early beat %0d got rvalid=%b expected 0", i, sf_rvalid);
      end
      sf_write(8'(8'h11 + i), (i == 3), 1'b0);
    end
    n_tests++;
    if ({sf_rvalid, sf_pkt_count} !== {1'b1, 5'd1}) begin
      n_fail++; $display("FAIL sf_latency_commit got rvalid=%b pkt=%0d expected 1 1", sf_rvalid, sf_pkt_count);
    end
    repeat (3) tick();
    n_tests++;
    if (sf_pkt_count !== 5'd1) begin
      n_fail++; $display("FAIL sf_pkt_mid got %0d expected 1", sf_pkt_count);
    end
    tick();
    n_tests++;
    if ({sf_rvalid, sf_pkt_count, sf_data_count} !== 11'd0 || sf_q.size() != 0) begin
      n_fail++; $display("FAIL sf_latency_drain got rvalid=%b pkt=%0d cnt=%0d left=%0d expected 0 0 0 0",
                         sf_rvalid, sf_pkt_count, sf_data_count, sf_q.size());
    end
    sf_rready = 0;
  endtask

  task automatic test_fill();
    sf_rready = 0;
    for (int i = 0; i < 16; i++) begin
      sf_q.push_back({1'b1, 8'(8'h20 + i)});
      sf_write(8'(8'h20 + i), 1'b1, 1'b0);
      n_tests++;
      if ({sf_data_count, sf_almost_full, sf_wready} !== {5'(i + 1), (i + 1 >= 14), (i + 1 < 16)}) begin
        n_fail++; $display("FAIL fill_%0d got cnt=%0d af=%b wready=%b expected %0d %b %b", i,
                           sf_data_count, sf_almost_full, sf_wready, i + 1, (i + 1 >= 14), (i + 1 < 16));
      end
    end
    tick(); tick();
    n_tests++;
    if ({sf_oversize, sf_pkt_count, sf_wready} !== {1'b0, 5'd16, 1'b0}) begin
      n_fail++; $display("FAIL fill_full got ov=%b pkt=%0d wready=%b expected 0 16 0",
                         sf_oversize, sf_pkt_count, sf_wready);
    end
    sf_rready = 1;
    tick();
    sf_rready = 0;
    n_tests++;
    if ({sf_wready, sf_data_count} !== {1'b1, 5'd15}) begin
      n_fail++; $display("FAIL fill_free got wready=%b cnt=%0d expected 1 15", sf_wready, sf_data_count);
    end
    sf_rready = 1;
    repeat (15) tick();
    sf_rready = 0;
    n_tests++;
    if ({sf_data_count, sf_almost_empty} !== {5'd0, 1'b1} || sf_q.size() != 0) begin
      n_fail++; $display("FAIL fill_drain got cnt=%0d ae=%b left=%0d expected 0 1 0",
                         sf_data_count, sf_almost_empty, sf_q.size());
    end
  endtask

  task automatic test_oversize();
    int beat = 0, cyc = 0, n_ov = 0;
    logic acc;
    logic [4:0] prev_cnt = '0, cnt_before_ov = '0, max_cnt = '0;
    sf_rready = 1;
    while (beat < 20 && cyc < 100) begin
      sf_wvalid = 1; sf_wdata = 8'(8'h40 + beat); sf_wlast = (beat == 19); sf_wdrop = 0;
      acc = sf_wready;
      prev_cnt = sf_data_count;
      tick();
      cyc++;
      if (acc) beat++;
      if (sf_oversize) begin n_ov++; cnt_before_ov = prev_cnt; end
      if (sf_data_count > max_cnt) max_cnt = sf_data_count;
    end
    sf_wvalid = 0; sf_wlast = 0;
    n_tests++;
    if (beat != 20) begin
      n_fail++; $display("FAIL oversize_timeout got %0d beats expected 20", beat);
    end
    n_tests++;
    if (n_ov != 1 || cnt_before_ov !== 5'd16 || max_cnt !== 5'd16) begin
      n_fail++; $display("FAIL oversize_pulse got pulses=%0d cnt_before=%0d max=%0d expected 1 16 16",
                         n_ov, cnt_before_ov, max_cnt);
    end
    n_tests++;
    if ({sf_data_count, sf_pkt_count, sf_rvalid} !== 11'd0) begin
      n_fail++; $display("FAIL oversize_discard got cnt=%0d pkt=%0d rvalid=%b expected 0 0 0",
                         sf_data_count, sf_pkt_count, sf_rvalid);
    end
    sf_q.push_back({1'b0, 8'h5A});
    sf_q.push_back({1'b1, 8'h5B});
    sf_write(8'h5A, 1'b0, 1'b0);
    sf_write(8'h5B, 1'b1, 1'b0);
    repeat (4) tick();
    n_tests++;
    if (sf_q.size() != 0 || sf_data_count !== 5'd0) begin
      n_fail++; $display("FAIL oversize_recover got left=%0d cnt=%0d expected 0 0", sf_q.size(), sf_data_count);
    end
    sf_rready = 0;
  endtask

  // Entries are {in_packet_b, wdrop, wlast, data}.
  localparam logic [10:0] DROP_TBL [8] = '{
    {1'b0, 1'b0, 1'b0, 8'h61}, {1'b0, 1'b0, 1'b0, 8'h62}, {1'b0, 1'b0, 1'b1, 8'h63},
    {1'b1, 1'b0, 1'b0, 8'h71}, {1'b1, 1'b0, 1'b0, 8'h72}, {1'b1, 1'b1, 1'b1, 8'h73},
    {1'b0, 1'b0, 1'b0, 8'h81}, {1'b0, 1'b0, 1'b1, 8'h82}
  };

  task automatic test_drop();
    int n_drop = 0;
    logic [10:0] e;
    sf_rready = 0;
    for (int i = 0; i < 8; i++) begin
      e = DROP_TBL[i];
      if (!(e[10] && EXP_DROP == 1)) sf_q.push_back(e[8:0]);
      sf_write(e[7:0], e[8], e[9]);
      if (sf_dropped) n_drop++;
    end
    tick();
    if (sf_dropped) n_drop++;
    n_tests++;
    if (n_drop != EXP_DROP || sf_pkt_count !== EXP_PKTS) begin
      n_fail++; $display("FAIL drop_pulse got pulses=%0d pkt=%0d expected %0d %0d",
                         n_drop, sf_pkt_count, EXP_DROP, EXP_PKTS);
    end
    sf_rready = 1;
    repeat (10) tick();
    sf_rready = 0;
    n_tests++;
    if (sf_q.size() != 0 || {sf_data_count, sf_pkt_count} !== 10'd0) begin
      n_fail++; $display("FAIL drop_drain got left=%0d cnt=%0d pkt=%0d expected 0 0 0",
                         sf_q.size(), sf_data_count, sf_pkt_count);
    end
  endtask

  task automatic test_cut_through();
    int wi = 1, cyc = 0;
    logic acc;
    logic [2:0] max_cnt = '0;
    ct_rready = 0;
    n_tests++;
    if (ct_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL ct_pre got rvalid=%b expected 0", ct_rvalid);
    end
    ct_wvalid = 1; ct_wdata = 8'h80; ct_wlast = 0;
    ct_q.push_back({1'b0, 8'h80});
    tick();
    n_tests++;
    if (ct_rvalid !== 1'b1) begin
      n_fail++; $display("FAIL ct_latency got rvalid=%b expected 1", ct_rvalid);
    end
    while ((wi < 12 || ct_q.size() != 0) && cyc < 400) begin
      if (wi < 12) begin
        ct_wvalid = 1; ct_wdata = 8'(8'h80 + wi); ct_wlast = (wi % 4 == 3);
      end else begin
        ct_wvalid = 0; ct_wlast = 0;
      end
      ct_rready = 1'($urandom_range(0, 1));
      acc = ct_wvalid && ct_wready;
      if (acc) ct_q.push_back({ct_wlast, ct_wdata});
      tick();
      cyc++;
      if (acc) wi++;
      if (ct_data_count > max_cnt) max_cnt = ct_data_count;
    end
    ct_wvalid = 0; ct_wlast = 0; ct_rready = 0;
    n_tests++;
    if (cyc >= 400) begin
      n_fail++; $display("FAIL ct_timeout got %0d written %0d left expected 12 0", wi, ct_q.size());
    end
    n_tests++;
    if (max_cnt > 3'd5) begin
      n_fail++; $display("FAIL ct_max_count got %0d expected <=5", max_cnt);
    end
    n_tests++;
    if ({ct_data_count, ct_pkt_count, ct_rvalid} !== 7'd0) begin
      n_fail++; $display("FAIL ct_end got cnt=%0d pkt=%0d rvalid=%b expected 0 0 0",
                         ct_data_count, ct_pkt_count, ct_rvalid);
    end
  endtask

  task automatic test_flush();
    sf_rready = 0;
    sf_write(8'h91, 1'b0, 1'b0);
    sf_write(8'h92, 1'b0, 1'b0);
    sf_write(8'h93, 1'b1, 1'b0);
    sf_write(8'hA1, 1'b0, 1'b0);
    sf_write(8'hA2, 1'b0, 1'b0);
    n_tests++;
    if ({sf_data_count, sf_pkt_count} !== {5'd5, 5'd1}) begin
      n_fail++; $display("FAIL flush_pre got cnt=%0d pkt=%0d expected 5 1", sf_data_count, sf_pkt_count);
    end
    sf_flush = 1; sf_wvalid = 1; sf_wdata = 8'hEE; sf_wlast = 1; sf_rready = 1;
    tick();
    sf_flush = 0; sf_wvalid = 0; sf_wlast = 0; sf_rready = 0;
    n_tests++;
    if (sf_status() !== SF_RST) begin
      n_fail++; $display("FAIL flush_state got %h expected %h", sf_status(), SF_RST);
    end
    sf_q.push_back({1'b0, 8'hB1});
    sf_q.push_back({1'b1, 8'hB2});
    sf_write(8'hB1, 1'b0, 1'b0);
    sf_write(8'hB2, 1'b1, 1'b0);
    sf_rready = 1;
    repeat (4) tick();
    sf_rready = 0;
    n_tests++;
    if (sf_q.size() != 0 || sf_data_count !== 5'd0) begin
      n_fail++; $display("FAIL flush_after got left=%0d cnt=%0d expected 0 0", sf_q.size(), sf_data_count);
    end
  endtask

  task automatic test_reset_mid_read();
    sf_rready = 0;
    for (int i = 0; i < 4; i++) begin
      sf_q.push_back({(i == 3), 8'(8'hC1 + i)});
      sf_write(8'(8'hC1 + i), (i == 3), 1'b0);
    end
    sf_rready = 1;
    tick(); tick();
    #2;
    reset = 1;
    #1;
    n_tests++;
    if (sf_status() !== SF_RST) begin
      n_fail++; $display("FAIL reset_mid_sf got %h expected %h", sf_status(), SF_RST);
    end
    n_tests++;
    if (sf_q.size() != 2) begin
      n_fail++; $display("FAIL reset_mid_reads got %0d words left expected 2", sf_q.size());
    end
    sf_q.delete();
    idle_all();
    tick();
    reset = 0;
    tick();
    sf_q.push_back({1'b1, 8'hD1});
    sf_write(8'hD1, 1'b1, 1'b0);
    sf_rready = 1;
    repeat (3) tick();
    sf_rready = 0;
    n_tests++;
    if (sf_q.size() != 0 || {sf_data_count, sf_pkt_count} !== 10'd0) begin
      n_fail++; $display("FAIL reset_after got left=%0d cnt=%0d pkt=%0d expected 0 0 0",
                         sf_q.size(), sf_data_count, sf_pkt_count);
    end
  endtask

  initial begin
    test_reset();
    test_sf_latency();
    test_fill();
    test_oversize();
    test_drop();
    test_cut_through();
    test_flush();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
